seat_table: RTL and testbench

Parametrised seat-assignment table, the successor to the fixed 32-seat, write-only student-number memory. It stores one student ID per seat with a per-seat occupancy bit and accepts four operations through a valid/ready request port: assign to a given seat, auto-assign to the first free seat, release, and find by ID. A one-entry-per-cycle scan rejects duplicate IDs. A registered read port and a free-seat counter serve the display and control logic.

---
 rtl/seat_table_if.sv | 24 ++
 rtl/seat_table.sv | 213 +++++++++++++++++++++
 tb/tb_seat_table.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seat_table_if.sv
// rtl/seat_table_if.sv - request/response handshake bundle for seat_table
interface seat_table_if #(
  parameter int ID_W   = 25,
  parameter int SEAT_W = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ID_W-1:0]   req_id;
  logic [SEAT_W-1:0] req_seat;
  logic              resp_valid;
  logic [1:0]        resp_status;
  logic [SEAT_W-1:0] resp_seat;

  modport master (
    output req_valid, req_op, req_id, req_seat,
    input  req_ready, resp_valid, resp_status, resp_seat
  );

  modport slave (
    input  req_valid, req_op, req_id, req_seat,
    output req_ready, resp_valid, resp_status, resp_seat
  );
endinterface

// File: rtl/seat_table.sv
// rtl/seat_table.sv - seat/ID table with duplicate-rejecting scan, read port and free counter
module seat_table #(
  parameter int ID_W   = 25,
  parameter int SEATS  = 32,
  parameter int SEAT_W = $clog2(SEATS),
  parameter int CNT_W  = $clog2(SEATS + 1)
) (
  input  logic              clk_seat_table,
  input  logic              reset_seat_table,
  seat_table_if.slave       bus,
  input  logic [SEAT_W-1:0] rd_seat,
  output logic [ID_W-1:0]   rd_id,
  output logic              rd_occupied,
  output logic [CNT_W-1:0]  free_count
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  localparam logic [1:0] OP_ASSIGN  = 2'b00;
  localparam logic [1:0] OP_AUTO    = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_FIND    = 2'b11;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DUP     = 2'b01;
  localparam logic [1:0] ST_BLOCKED = 2'b10;
  localparam logic [1:0] ST_NOTFND  = 2'b11;
  localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(SEATS - 1);
  localparam logic [CNT_W-1:0]  SEATS_CNT = CNT_W'(SEATS);

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [ID_W-1:0]   id_q;
  logic [SEAT_W-1:0] seat_q, idx_q;
  logic              match_q, match_d, free_q, free_d;
  logic [SEAT_W-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [ID_W-1:0]   id_mem [SEATS];
  logic [SEATS-1:0]  occ_q;
  logic [CNT_W-1:0]  free_cnt_q;
  logic [1:0]        status_q, status_d;
  logic [SEAT_W-1:0] rseat_q, rseat_d;
  logic [ID_W-1:0]   rd_id_q;
  logic              rd_occ_q;

  logic              accept, last_scan, commit, hit;
  logic [1:0]        cur_op;
  logic [SEAT_W-1:0] cur_seat, wr_seat;
  logic              cur_seat_ok, rd_seat_ok;
  logic              wr_en, clr_en;

  // With a power-of-two table every encodable index is a real seat.
  generate
    if (SEATS == (1 << SEAT_W)) begin : g_full_range
      assign cur_seat_ok = 1'b1;
      assign rd_seat_ok  = 1'b1;
    end else begin : g_part_range
      assign cur_seat_ok = (cur_seat <= LAST_SEAT);
      assign rd_seat_ok  = (rd_seat <= LAST_SEAT);
    end
  endgenerate

  assign accept    = bus.req_valid && bus.req_ready;
  assign last_scan = (state_q == SCAN) && (idx_q == LAST_SEAT);
  assign commit    = (accept && (bus.req_op == OP_RELEASE)) || last_scan;
  assign cur_op    = (state_q == IDLE) ? bus.req_op : op_q;
  assign cur_seat  = (state_q == IDLE) ? bus.req_seat : seat_q;

  always_ff @(posedge clk_seat_table) begin
    if (reset_seat_table) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.req_op == OP_RELEASE) ? RESP : SCAN;
      SCAN:    if (idx_q == LAST_SEAT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !reset_seat_table;
    bus.resp_valid = (state_q == RESP);
  end

  // The current entry is folded in so the final scan cycle can commit directly.
  always_comb begin
    hit         = occ_q[idx_q] && (id_mem[idx_q] == id_q);
    match_d     = match_q;
    match_idx_d = match_idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    if (state_q == SCAN) begin
      if (!match_q && hit) begin
        match_d     = 1'b1;
        match_idx_d = idx_q;
      end
      if (!free_q && !occ_q[idx_q]) begin
        free_d     = 1'b1;
        free_idx_d = idx_q;
      end
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    clr_en   = 1'b0;
    wr_seat  = cur_seat;
    status_d = status_q;
    rseat_d  = rseat_q;
    if (commit) begin
      case (cur_op)
        OP_ASSIGN: begin
          if (match_d) begin
            status_d = ST_DUP;
            rseat_d  = match_idx_d;
          end else if (!cur_seat_ok || occ_q[cur_seat]) begin
            status_d = ST_BLOCKED;
            rseat_d  = cur_seat;
          end else begin
            wr_en    = 1'b1;
            status_d = ST_OK;
            rseat_d  = cur_seat;
          end
        end
        OP_AUTO: begin
          if (match_d) begin
            status_d = ST_DUP;
            rseat_d  = match_idx_d;
          end else if (!free_d) begin
            status_d = ST_BLOCKED;
            rseat_d  = '0;
          end else begin
            wr_en    = 1'b1;
            wr_seat  = free_idx_d;
            status_d = ST_OK;
            rseat_d  = free_idx_d;
          end
        end
        OP_FIND: begin
          status_d = match_d ? ST_OK : ST_NOTFND;
          rseat_d  = match_d ? match_idx_d : '0;
        end
        default: begin
          rseat_d = cur_seat;
          if (!cur_seat_ok || !occ_q[cur_seat]) begin
            status_d = ST_NOTFND;
          end else begin
            clr_en   = 1'b1;
            status_d = ST_OK;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_seat_table) begin
    if (reset_seat_table) begin
      op_q        <= '0;
      id_q        <= '0;
      seat_q      <= '0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
      occ_q       <= '0;
      free_cnt_q  <= SEATS_CNT;
      status_q    <= ST_OK;
      rseat_q     <= '0;
      rd_id_q     <= '0;
      rd_occ_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        id_q    <= bus.req_id;
        seat_q  <= bus.req_seat;
        idx_q   <= '0;
        match_q <= 1'b0;
        free_q  <= 1'b0;
      end else if (state_q == SCAN) begin
        idx_q       <= idx_q + 1'b1;
        match_q     <= match_d;
        match_idx_q <= match_idx_d;
        free_q      <= free_d;
        free_idx_q  <= free_idx_d;
      end
      if (wr_en) begin
        occ_q[wr_seat] <= 1'b1;
        free_cnt_q     <= free_cnt_q - 1'b1;
      end
      if (clr_en) begin
        occ_q[cur_seat] <= 1'b0;
        free_cnt_q      <= free_cnt_q + 1'b1;
      end
      status_q <= status_d;
      rseat_q  <= rseat_d;
      rd_occ_q <= rd_seat_ok && occ_q[rd_seat];
      if (rd_seat_ok) rd_id_q <= id_mem[rd_seat];
    end
  end

  // ID words are never cleared; only occupancy says whether one is live.
  always_ff @(posedge clk_seat_table) begin
    if (!reset_seat_table && wr_en) id_mem[wr_seat] <= id_q;
  end

  assign bus.resp_status = status_q;
  assign bus.resp_seat   = rseat_q;
  assign rd_id           = rd_id_q;
  assign rd_occupied     = rd_occ_q;
  assign free_count      = free_cnt_q;
endmodule

// File: tb/tb_seat_table.sv
// tb/tb_seat_table.sv - randomized and directed bench for seat_table against a table model
module tb_seat_table;
  localparam int ID_W   = 25;
  localparam int SEATS  = 32;
  localparam int SEAT_W = 5;
  localparam int CNT_W  = 6;
  localparam logic [1:0] OP_ASSIGN = 2'd0, OP_AUTO = 2'd1, OP_RELEASE = 2'd2, OP_FIND = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_DUP = 2'd1, ST_BLK = 2'd2, ST_NF = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SEAT_W-1:0] rd_seat;
  logic [ID_W-1:0]   rd_id;
  logic              rd_occupied;
  logic [CNT_W-1:0]  free_count;
  bit                rd_hold = 1'b0;
  logic [SEAT_W-1:0] rd_fix = '0;

  seat_table_if #(.ID_W(ID_W), .SEAT_W(SEAT_W)) bus ();

  seat_table #(.ID_W(ID_W), .SEATS(SEATS)) dut (
    .clk_seat_table  (clk),
    .reset_seat_table(rst),
    .bus             (bus),
    .rd_seat         (rd_seat),
    .rd_id           (rd_id),
    .rd_occupied     (rd_occupied),
    .free_count      (free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference table state
  bit              m_occ [SEATS];
  bit              m_wr  [SEATS];
  logic [ID_W-1:0] m_id  [SEATS];
  bit              pending = 1'b0;
  int              busy_lo, resp_cyc, p_kind, p_seat;
  logic [ID_W-1:0] p_id;
  logic [1:0]        e_st;
  logic [SEAT_W-1:0] e_sd;
  bit              prev_rst = 1'b0, armed = 1'b0;
  logic            exp_rd_occ = 1'b0;
  bit              exp_rd_known = 1'b0;
  logic [ID_W-1:0] exp_rd_id = '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void predict(input logic [1:0] op, input logic [ID_W-1:0] id,
                                  input logic [SEAT_W-1:0] seat);
    int m = -1;
    int f = -1;
    for (int i = 0; i < SEATS; i++) begin
      if (m < 0 && m_occ[i] && m_id[i] == id) m = i;
      if (f < 0 && !m_occ[i]) f = i;
    end
    p_kind = 0; p_seat = int'(seat); p_id = id;
    case (op)
      OP_ASSIGN:
        if (m >= 0)           begin e_st = ST_DUP; e_sd = SEAT_W'(m); end
        else if (m_occ[seat]) begin e_st = ST_BLK; e_sd = seat; end
        else                  begin e_st = ST_OK;  e_sd = seat; p_kind = 1; end
      OP_AUTO:
        if (m >= 0)     begin e_st = ST_DUP; e_sd = SEAT_W'(m); end
        else if (f < 0) begin e_st = ST_BLK; e_sd = '0; end
        else            begin e_st = ST_OK;  e_sd = SEAT_W'(f); p_kind = 1; p_seat = f; end
      OP_FIND:
        if (m >= 0) begin e_st = ST_OK; e_sd = SEAT_W'(m); end
        else        begin e_st = ST_NF; e_sd = '0; end
      default:
        if (m_occ[seat]) begin e_st = ST_OK; e_sd = seat; p_kind = 2; end
        else             begin e_st = ST_NF; e_sd = seat; end
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    rd_seat = rd_hold ? rd_fix : SEAT_W'($urandom_range(0, SEATS - 1));
  end

  // Per-cycle comparison of every output against the table model
  always @(negedge clk) begin : cmp
    bit is_resp, exp_ready;
    int fc;
    if (prev_rst) begin
      for (int i = 0; i < SEATS; i++) m_occ[i] = 1'b0;
      pending = 1'b0;
      armed   = 1'b1;
    end else if (pending && cyc == resp_cyc) begin
      if (p_kind == 1) begin
        m_occ[p_seat] = 1'b1; m_id[p_seat] = p_id; m_wr[p_seat] = 1'b1;
      end else if (p_kind == 2) begin
        m_occ[p_seat] = 1'b0;
      end
    end
    exp_ready = 1'b0;
    if (armed) begin
      exp_ready = !rst && !(pending && cyc >= busy_lo && cyc <= resp_cyc);
      is_resp   = pending && cyc == resp_cyc;
      chk("req_ready", bus.req_ready, exp_ready);
      chk("resp_valid", bus.resp_valid, is_resp);
      if (is_resp) begin
        chk("resp_status", bus.resp_status, e_st);
        chk("resp_seat", bus.resp_seat, e_sd);
        pending = 1'b0;
      end
      fc = SEATS;
      for (int i = 0; i < SEATS; i++) fc -= int'(m_occ[i]);
      chk("free_count", free_count, fc);
      chk("rd_occupied", rd_occupied, exp_rd_occ);
      if (exp_rd_known) chk("rd_id", rd_id, exp_rd_id);
    end
    if (rst) begin
      exp_rd_occ = 1'b0; exp_rd_known = 1'b1; exp_rd_id = '0;
    end else begin
      exp_rd_occ = m_occ[rd_seat]; exp_rd_known = m_wr[rd_seat]; exp_rd_id = m_id[rd_seat];
    end
    if (armed && exp_ready && bus.req_valid) begin
      predict(bus.req_op, bus.req_id, bus.req_seat);
      pending  = 1'b1;
      busy_lo  = cyc + 1;
      resp_cyc = cyc + 1 + ((bus.req_op == OP_RELEASE) ? 0 : SEATS);
    end
    prev_rst = rst;
  end

  task automatic do_req(input logic [1:0] op, input logic [ID_W-1:0] id,
                        input logic [SEAT_W-1:0] seat,
                        output logic [1:0] st, output logic [SEAT_W-1:0] sd);
    int lat = 0;
    bit got = 1'b0;
    st = '0; sd = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_id = id; bus.req_seat = seat;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i <= SEATS + 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        st = bus.resp_status; sd = bus.resp_seat; lat = i; got = 1'b1;
        bus.req_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 2'($urandom_range(0, 3));
      bus.req_id    = ID_W'($urandom);
      bus.req_seat  = SEAT_W'($urandom);
    end
    bus.req_valid = 1'b0;
    chk("resp_seen", got, 1);
    if (got) chk("latency", lat, (op == OP_RELEASE) ? 1 : SEATS + 1);
  endtask

  task automatic tp(input string nm, input logic [1:0] op, input logic [ID_W-1:0] id,
                    input logic [SEAT_W-1:0] seat, input logic [1:0] xst, input logic [SEAT_W-1:0] xsd);
    logic [1:0] st;
    logic [SEAT_W-1:0] sd;
    do_req(op, id, seat, st, sd);
    chk({nm, "_status"}, st, xst);
    chk({nm, "_seat"}, sd, xsd);
  endtask

  task automatic chk_free(input string nm, input int v);
    @(negedge clk);
    chk(nm, free_count, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] st;
    logic [SEAT_W-1:0] sd;
    int nresp;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_id = '0; bus.req_seat = '0;
    rd_seat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_free_count", free_count, SEATS);
    chk("reset_ready", bus.req_ready, 1);

    tp("rel_empty", OP_RELEASE, 0, 3, ST_NF, 3);
    chk_free("free_after_rel_empty", 32);
    tp("assign5", OP_ASSIGN, 25'h1ABCDEF, 5, ST_OK, 5);
    chk_free("free_after_assign5", 31);
    rd_hold = 1'b1; rd_fix = 5;
    repeat (2) @(negedge clk);
    chk("rd5_id", rd_id, 25'h1ABCDEF);
    chk("rd5_occ", rd_occupied, 1);
    rd_hold = 1'b0;
    tp("dup", OP_ASSIGN, 25'h1ABCDEF, 9, ST_DUP, 5);
    tp("blocked", OP_ASSIGN, 7, 5, ST_BLK, 5);
    chk_free("free_after_blocked", 31);

    for (int k = 0; k < 5; k++) tp("auto_fill", OP_AUTO, ID_W'(10 + k), 0, ST_OK, SEAT_W'(k));
    tp("auto_skip5", OP_AUTO, 20, 0, ST_OK, 6);
    tp("find12", OP_FIND, 12, 0, ST_OK, 2);
    tp("find99", OP_FIND, 99, 0, ST_NF, 0);

    for (int k = 7; k < SEATS; k++) tp("auto_rest", OP_AUTO, ID_W'(100 + k), 0, ST_OK, SEAT_W'(k));
    tp("auto_full", OP_AUTO, 500, 0, ST_BLK, 0);
    chk_free("free_full", 0);
    tp("dup_over_full", OP_AUTO, 10, 0, ST_DUP, 0);
    tp("rel17", OP_RELEASE, 0, 17, ST_OK, 17);
    chk_free("free_after_rel17", 1);
    tp("auto_refill17", OP_AUTO, 501, 0, ST_OK, 17);

    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = OP_AUTO; bus.req_id = 555; bus.req_seat = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    nresp = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (SEATS + 4) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("abort_no_resp", nresp, 0);
    chk("abort_free_count", free_count, SEATS);
    tp("find_after_reset", OP_FIND, 10, 0, ST_NF, 0);
    tp("assign_id0", OP_ASSIGN, 0, 31, ST_OK, 31);
    tp("find_id0", OP_FIND, 0, 0, ST_OK, 31);

    repeat (60) begin
      do_req(2'($urandom_range(0, 3)), ID_W'($urandom_range(0, 15)),
             SEAT_W'($urandom_range(0, SEATS - 1)), st, sd);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
